// File: rtl/fetch_order_monitor.sv
// Fetch order checker and performance monitor: tracks outstanding fetch requests
// in an in-order queue, flags response mismatches, and counts cycles/requests/retires.
module fetch_order_monitor #(
    parameter int                      ADDRESS_BITS = 12,
    parameter int                      DEPTH        = 4,
    parameter int                      COUNT_BITS   = 32,
    parameter logic [ADDRESS_BITS-1:0] END_PC       = 12'h0B0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic [ADDRESS_BITS-1:0] req_address,
    input  logic                    rsp_valid,
    input  logic [ADDRESS_BITS-1:0] rsp_address,
    input  logic                    flush,
    input  logic                    retire_valid,
    input  logic [ADDRESS_BITS-1:0] retire_pc,
    input  logic                    clear_counters,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic                    full,
    output logic                    empty,
    output logic                    order_err,
    output logic                    overflow_err,
    output logic                    underflow_err,
    output logic [ADDRESS_BITS-1:0] err_expected,
    output logic [ADDRESS_BITS-1:0] err_actual,
    output logic [COUNT_BITS-1:0]   error_count,
    output logic [COUNT_BITS-1:0]   cycle_count,
    output logic [COUNT_BITS-1:0]   request_count,
    output logic [COUNT_BITS-1:0]   retire_count,
    output logic                    done,
    output logic [COUNT_BITS-1:0]   done_cycles
);

    localparam int                  PTR_BITS    = $clog2(DEPTH);
    localparam logic [PTR_BITS:0]   DEPTH_COUNT = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0]   OCC_ONE     = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS-1:0] PTR_ONE     = PTR_BITS'(1);

    logic [ADDRESS_BITS-1:0] entries [DEPTH];
    logic [PTR_BITS-1:0]     read_ptr, write_ptr;
    logic [PTR_BITS-1:0]     read_ptr_next, write_ptr_next, write_slot;
    logic [PTR_BITS:0]       outstanding_next;
    logic [ADDRESS_BITS-1:0] head;
    logic                    pop, push, underflow, overflow, mismatch;
    logic                    error_event, finishing;

    function automatic logic [COUNT_BITS-1:0] bump(input logic [COUNT_BITS-1:0] value,
                                                   input logic                  enable);
        return (enable && value != '1) ? value + COUNT_BITS'(1) : value;
    endfunction

    // Decisions use registered occupancy, so a rsp never bypasses a same-cycle req.
    assign head        = entries[read_ptr];
    assign pop         = rsp_valid & ~flush & ~empty;
    assign underflow   = rsp_valid & ~flush & empty;
    assign push        = req_valid & (flush | ~full | pop);
    assign overflow    = req_valid & ~flush & full & ~pop;
    assign mismatch    = pop & (head != rsp_address);
    assign error_event = mismatch | overflow | underflow;
    assign finishing   = retire_valid & (retire_pc == END_PC) & ~done;
    assign write_slot  = flush ? '0 : write_ptr;

    always_comb begin
        read_ptr_next    = read_ptr;
        write_ptr_next   = write_ptr;
        outstanding_next = outstanding;
        if (flush) begin
            read_ptr_next    = '0;
            write_ptr_next   = push ? PTR_ONE : '0;
            outstanding_next = push ? OCC_ONE : '0;
        end else begin
            if (pop)
                read_ptr_next = read_ptr + PTR_ONE;
            if (push)
                write_ptr_next = write_ptr + PTR_ONE;
            if (push && !pop)
                outstanding_next = outstanding + OCC_ONE;
            else if (pop && !push)
                outstanding_next = outstanding - OCC_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            entries[write_slot] <= req_address;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_ptr      <= '0;
            write_ptr     <= '0;
            outstanding   <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            order_err     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            err_expected  <= '0;
            err_actual    <= '0;
            error_count   <= '0;
            cycle_count   <= '0;
            request_count <= '0;
            retire_count  <= '0;
            done          <= 1'b0;
            done_cycles   <= '0;
        end else begin
            read_ptr    <= read_ptr_next;
            write_ptr   <= write_ptr_next;
            outstanding <= outstanding_next;
            full        <= (outstanding_next == DEPTH_COUNT);
            empty       <= (outstanding_next == '0);

            // Only the first mismatch is captured; later ones just count.
            if (mismatch) begin
                order_err <= 1'b1;
                if (!order_err) begin
                    err_expected <= head;
                    err_actual   <= rsp_address;
                end
            end
            if (overflow)
                overflow_err <= 1'b1;
            if (underflow)
                underflow_err <= 1'b1;

            if (clear_counters) begin
                error_count   <= '0;
                cycle_count   <= '0;
                request_count <= '0;
                retire_count  <= '0;
            end else if (!done) begin
                cycle_count   <= bump(cycle_count, 1'b1);
                request_count <= bump(request_count, req_valid);
                retire_count  <= bump(retire_count, retire_valid);
                error_count   <= bump(error_count, error_event);
            end

            // done_cycles takes the pre-edge count, i.e. cycles elapsed before this retire.
            if (finishing) begin
                done        <= 1'b1;
                done_cycles <= cycle_count;
            end
        end
    end

endmodule
